// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between one master and the interconnect/slave side.
// Latency: none (wires only).
// Backpressure: HREADY from the slave side stalls the master.
interface ahb_lite_master_if;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite master: turns application requests into pipelined SINGLE/INCR transfers.
// Latency: request -> address phase +1 cycle -> data phase +2; read data returned combinationally.
// Backpressure: HREADY=0 freezes address/data phase state; WAIT tells the application to hold.
module ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  ahb_lite_master_if.master ahb,
  input  logic [31:0] data_in,
  input  logic [31:0] addr,
  input  logic [3:0]  opcode,
  input  logic        enable,
  input  logic        new_trans,
  input  logic        busy,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        error,
  output logic        WAIT
);

  // State encoding equals the HTRANS code so the state register drives the bus directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_NONSEQ = 2'b10,
    ST_SEQ    = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_haddr;
  logic        r_hwrite;
  logic [2:0]  r_hsize;
  logic [2:0]  r_hburst;
  logic [31:0] r_hwdata;

  // Data phase context captured when the address phase completes.
  logic        r_dp_vld;
  logic        r_dp_write;
  logic [1:0]  r_dp_size;
  logic [1:0]  r_dp_lane;
  logic [31:0] r_rdata;

  logic        w_xfer;
  logic        w_err_first;
  logic        w_rd_done;
  logic [31:0] w_lane;

  // Only NONSEQ and SEQ carry a data phase; IDLE and BUSY do not.
  assign w_xfer      = (r_state == ST_NONSEQ) || (r_state == ST_SEQ);
  // First cycle of the two-cycle ERROR response: the pipelined address is dropped.
  assign w_err_first = r_dp_vld && ahb.HRESP && !ahb.HREADY;
  assign w_rd_done   = r_dp_vld && !r_dp_write && ahb.HREADY && !ahb.HRESP;

  // Address phase FSM; outputs are registered alongside the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= '0;
      r_hburst <= '0;
    end else if (w_err_first) begin
      r_state <= ST_IDLE;
    end else if (ahb.HREADY) begin
      if (!enable) begin
        r_state <= ST_IDLE;
      end else if (new_trans) begin
        r_state  <= ST_NONSEQ;
        r_haddr  <= addr;
        r_hwrite <= opcode[2];
        r_hsize  <= {1'b0, opcode[1:0]};
        r_hburst <= {2'b00, opcode[3]};
      end else if (opcode[3] && busy) begin
        // Application paused mid-burst: address and controls stay put.
        r_state <= ST_BUSY;
      end else if (opcode[3]) begin
        r_state  <= ST_SEQ;
        r_haddr  <= addr;
        r_hwrite <= opcode[2];
        r_hsize  <= {1'b0, opcode[1:0]};
        r_hburst <= {2'b00, opcode[3]};
      end else begin
        // Continuation of a non-burst request means the transaction is over.
        r_state <= ST_IDLE;
      end
    end
  end

  // Advance the data phase and capture write data when an address phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_vld   <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_size  <= '0;
      r_dp_lane  <= '0;
      r_hwdata   <= '0;
    end else if (ahb.HREADY) begin
      r_dp_vld   <= w_xfer;
      r_dp_write <= r_hwrite;
      r_dp_size  <= r_hsize[1:0];
      r_dp_lane  <= r_haddr[1:0];
      if (w_xfer && r_hwrite) begin
        r_hwdata <= data_in;
      end
    end
  end

  // Pick the addressed byte/halfword lane out of HRDATA and zero-extend it.
  always_comb begin
    w_lane = ahb.HRDATA;
    case (r_dp_size)
      2'd0: begin
        case (r_dp_lane)
          2'd0:    w_lane = {24'd0, ahb.HRDATA[7:0]};
          2'd1:    w_lane = {24'd0, ahb.HRDATA[15:8]};
          2'd2:    w_lane = {24'd0, ahb.HRDATA[23:16]};
          default: w_lane = {24'd0, ahb.HRDATA[31:24]};
        endcase
      end
      2'd1: begin
        w_lane = r_dp_lane[1] ? {16'd0, ahb.HRDATA[31:16]} : {16'd0, ahb.HRDATA[15:0]};
      end
      default: w_lane = ahb.HRDATA;
    endcase
  end

  // Hold the last completed read so data_out stays stable between reads.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rdata <= '0;
    end else if (w_rd_done) begin
      r_rdata <= w_lane;
    end
  end

  assign ahb.HADDR     = r_haddr;
  assign ahb.HWRITE    = r_hwrite;
  assign ahb.HSIZE     = r_hsize;
  assign ahb.HBURST    = r_hburst;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HTRANS    = r_state;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA    = r_hwdata;

  // Read data is forwarded in the completing cycle, otherwise the held value.
  assign data_out   = w_rd_done ? w_lane : r_rdata;
  assign data_valid = w_rd_done;
  assign error      = r_dp_vld && ahb.HRESP;
  assign WAIT       = !ahb.HREADY && ((r_state != ST_IDLE) || r_dp_vld);

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] data_in, addr;
  logic [3:0]  opcode;
  logic        enable, new_trans, busy;
  logic [31:0] data_out;
  logic        data_valid, error, WAIT;

  ahb_lite_master_if bus();

  ahb_lite_master dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .ahb        (bus),
    .data_in    (data_in),
    .addr       (addr),
    .opcode     (opcode),
    .enable     (enable),
    .new_trans  (new_trans),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .error      (error),
    .WAIT       (WAIT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        en;
    logic        nt;
    logic        bsy;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
  } slot_t;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model state: requests waiting, address phase, data phase.
  slot_t       slot_q[$];
  logic        rdy_q[$];
  bit          rand_wait   = 0;
  bit          use_fixed   = 0;
  logic [31:0] fixed_rdata = 32'h0;
  slot_t       a_slot, d_slot;
  int          a_kind = 0;   // 0 none, 1 busy, 2 transfer
  bit          d_v = 0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] last_xfer_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t mk(input logic en, input logic nt, input logic bsy,
                               input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    slot_t s;
    s.en = en; s.nt = nt; s.bsy = bsy; s.op = op; s.addr = a; s.wd = wd;
    return s;
  endfunction

  // Which bus transfer type a request produces.
  function automatic int kind(input slot_t s);
    if (!s.en) return 0;
    if (s.nt) return 2;
    if (s.op[3]) return s.bsy ? 1 : 2;
    return 0;
  endfunction

  // Zero-extended lane a load of the given size/offset should return.
  function automatic logic [31:0] lane(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] sh;
    if (sz == 2'd0) begin
      sh = d >> (8 * int'(a));
      return sh & 32'h0000_00FF;
    end
    if (sz == 2'd1) begin
      sh = d >> (16 * int'(a[1]));
      return sh & 32'h0000_FFFF;
    end
    return d;
  endfunction

  task automatic drive_app(input slot_t s);
    enable = s.en; new_trans = s.nt; busy = s.bsy; opcode = s.op; addr = s.addr;
  endtask

  // Runs until all queued requests have drained through both pipeline stages.
  task automatic run(input int max_cycles);
    int          cyc;
    logic        rdy;
    logic [31:0] hrd, exp_rd;
    slot_t       cur, idle_s;
    bit          rd_done;
    cyc = 0;
    idle_s = mk(0, 0, 0, 4'h0, 32'h0, 32'h0);
    while ((slot_q.size() != 0 || a_kind != 0 || d_v) && cyc < max_cycles) begin
      @(negedge HCLK);
      cyc++;
      rdy = 1'b1;
      if (d_v) begin
        if (rdy_q.size() != 0) rdy = rdy_q.pop_front();
        else if (rand_wait) rdy = ($urandom_range(0, 3) != 0);
      end
      hrd = use_fixed ? fixed_rdata : $urandom();
      bus.HREADY = rdy; bus.HRESP = 1'b0; bus.HRDATA = hrd;
      cur = (slot_q.size() != 0) ? slot_q[0] : idle_s;
      drive_app(cur);
      data_in = a_slot.wd;
      #1;
      chk("htrans", {30'd0, bus.HTRANS},
          (a_kind == 0) ? 32'd0 : (a_kind == 1) ? 32'd1 : (a_slot.nt ? 32'd2 : 32'd3));
      if (a_kind == 1) chk("haddr_busy_hold", bus.HADDR, last_xfer_addr);
      if (a_kind == 2) begin
        chk("haddr", bus.HADDR, a_slot.addr);
        chk("hwrite", {31'd0, bus.HWRITE}, {31'd0, a_slot.op[2]});
        chk("hsize", {29'd0, bus.HSIZE}, {30'd0, a_slot.op[1:0]});
        chk("hburst", {29'd0, bus.HBURST}, {31'd0, a_slot.op[3]});
      end
      chk("wait", {31'd0, WAIT}, {31'd0, (!rdy && (a_kind != 0 || d_v))});
      chk("error", {31'd0, error}, 32'd0);
      rd_done = d_v && !d_slot.op[2] && rdy;
      exp_rd  = rd_done ? lane(hrd, d_slot.addr[1:0], d_slot.op[1:0]) : last_rd;
      chk("data_valid", {31'd0, data_valid}, {31'd0, rd_done});
      chk("data_out", data_out, exp_rd);
      if (d_v && d_slot.op[2]) chk("hwdata", bus.HWDATA, d_slot.wd);
      @(posedge HCLK);
      if (rdy) begin
        if (rd_done) last_rd = exp_rd;
        d_v    = (a_kind == 2);
        d_slot = a_slot;
        a_kind = kind(cur);
        a_slot = cur;
        if (a_kind == 2) last_xfer_addr = cur.addr;
        if (slot_q.size() != 0) void'(slot_q.pop_front());
      end
    end
    chk("drain_pending", slot_q.size() + a_kind + int'(d_v), 0);
  endtask

  task automatic gen_random(input int n);
    int          r, len;
    logic [3:0]  op;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        slot_q.push_back(mk(0, 0, 0, 4'h0, 32'h0, 32'h0));
      end else if (r < 7) begin
        op = {1'b0, 3'($urandom_range(0, 7))};
        slot_q.push_back(mk(1, 1, 0, op, $urandom(), $urandom()));
      end else begin
        op  = {1'b1, 3'($urandom_range(0, 7))};
        a   = $urandom();
        len = $urandom_range(2, 4);
        for (int b = 0; b < len; b++) begin
          if (b > 0 && $urandom_range(0, 2) == 0)
            slot_q.push_back(mk(1, 0, 1, op, a + 32'h100, 32'h0));
          slot_q.push_back(mk(1, (b == 0), 0, op, a, $urandom()));
          a = a + 32'd4;
        end
        if ($urandom_range(0, 1) == 1)
          slot_q.push_back(mk(1, 0, 0, {1'b0, op[2:0]}, 32'h0, 32'h0));
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    enable = 0; new_trans = 0; busy = 0; opcode = 4'h0; addr = 32'h0; data_in = 32'h0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h1234_5678;
    a_slot = mk(0, 0, 0, 4'h0, 32'h0, 32'h0);
    d_slot = a_slot;
    #2;
    chk("rst_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_hwrite", {31'd0, bus.HWRITE}, 32'd0);
    chk("rst_hsize", {29'd0, bus.HSIZE}, 32'd0);
    chk("rst_hburst", {29'd0, bus.HBURST}, 32'd0);
    chk("rst_hwdata", bus.HWDATA, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_wait", {31'd0, WAIT}, 32'd0);
    chk("hprot", {28'd0, bus.HPROT}, 32'h3);
    chk("hmastlock", {31'd0, bus.HMASTLOCK}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single store word.
    slot_q.push_back(mk(1, 1, 0, 4'h6, 32'h1, 32'hAABB_CCDD));
    run(50);
    // Single load word with one wait state.
    use_fixed = 1; fixed_rdata = 32'hAABB_CCDD;
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    slot_q.push_back(mk(1, 1, 0, 4'h2, 32'h0, 32'h0));
    run(50);
    chk("load_word_held", data_out, 32'hAABB_CCDD);
    // Back-to-back stores.
    slot_q.push_back(mk(1, 1, 0, 4'h6, 32'h1, 32'hAABB_CCDD));
    slot_q.push_back(mk(1, 1, 0, 4'h6, 32'h2, 32'hABCD_EF00));
    run(50);
    // Store burst with one BUSY cycle, then end.
    slot_q.push_back(mk(1, 1, 0, 4'hE, 32'h1, 32'h1111_0001));
    slot_q.push_back(mk(1, 0, 0, 4'hE, 32'h2, 32'h1111_0002));
    slot_q.push_back(mk(1, 0, 1, 4'hE, 32'h99, 32'h0));
    slot_q.push_back(mk(1, 0, 0, 4'hE, 32'h3, 32'h1111_0003));
    slot_q.push_back(mk(1, 0, 0, 4'h6, 32'h0, 32'h0));
    run(50);
    // Byte and halfword loads at odd lanes.
    fixed_rdata = 32'h8877_6655;
    slot_q.push_back(mk(1, 1, 0, 4'h0, 32'h3, 32'h0));
    slot_q.push_back(mk(1, 1, 0, 4'h1, 32'h2, 32'h0));
    run(50);
    chk("load_half_hi", data_out, 32'h0000_8877);

    // Error response: pending NONSEQ behind the failing read is cancelled.
    @(negedge HCLK);
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    drive_app(mk(1, 1, 0, 4'h2, 32'h10, 32'h0));
    @(posedge HCLK); @(negedge HCLK);
    drive_app(mk(1, 1, 0, 4'h2, 32'h20, 32'h0));
    #1;
    chk("err_setup_haddr", bus.HADDR, 32'h10);
    @(posedge HCLK); @(negedge HCLK);
    enable = 1'b0; bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    #1;
    chk("err1_error", {31'd0, error}, 32'd1);
    chk("err1_wait", {31'd0, WAIT}, 32'd1);
    chk("err1_htrans", {30'd0, bus.HTRANS}, 32'd2);
    @(posedge HCLK); @(negedge HCLK);
    bus.HREADY = 1'b1;
    #1;
    chk("err2_error", {31'd0, error}, 32'd1);
    chk("err2_htrans_idle", {30'd0, bus.HTRANS}, 32'd0);
    chk("err2_data_valid", {31'd0, data_valid}, 32'd0);
    chk("err2_data_out", data_out, last_rd);
    @(posedge HCLK); @(negedge HCLK);
    bus.HREADY = 1'b0; bus.HRESP = 1'b0;
    #1;
    chk("err_cancel_wait", {31'd0, WAIT}, 32'd0);
    chk("err_cancel_error", {31'd0, error}, 32'd0);
    @(posedge HCLK);

    // Randomized traffic with random wait states.
    use_fixed = 0; rand_wait = 1;
    gen_random(300);
    run(5000);
    rand_wait = 0;

    // Reset asserted while a store is in flight.
    @(negedge HCLK);
    bus.HREADY = 1'b1;
    drive_app(mk(1, 1, 0, 4'h6, 32'h44, 32'h0));
    @(posedge HCLK); @(negedge HCLK);
    enable = 1'b0; bus.HREADY = 1'b0;
    #1;
    chk("mid_wait_before", {31'd0, WAIT}, 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk("mid_rst_haddr", bus.HADDR, 32'd0);
    chk("mid_rst_wait", {31'd0, WAIT}, 32'd0);
    chk("mid_rst_data_out", data_out, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.HREADY = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
